// File: rtl/mq_pass_length_recorder_pkg.sv
// Shared definitions for the MQ pass-length recorder: pass codes, FSM states,
// default widths and record layout helpers.
package mq_pass_length_recorder_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int BP_W_DEF       = 5;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int REC_PASS_W     = 2;

  localparam logic [REC_PASS_W-1:0] PASS_FINAL = 2'b00;
  localparam logic [REC_PASS_W-1:0] PASS_SP    = 2'b01;
  localparam logic [REC_PASS_W-1:0] PASS_MRP   = 2'b10;
  localparam logic [REC_PASS_W-1:0] PASS_CP    = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  // Record is {last, pass, bp, len}; len occupies the LSBs.
  function automatic int rec_last_bit(int cnt_w, int bp_w);
    return cnt_w + bp_w + REC_PASS_W;
  endfunction

  function automatic int rec_bp_lsb(int cnt_w);
    return cnt_w;
  endfunction

endpackage

// File: rtl/mq_pass_length_recorder_if.sv
// Pass-record handshake between the recorder (master) and the packet-header
// builder (slave).
interface mq_pass_length_recorder_if #(
  parameter int CNT_W = 16,
  parameter int BP_W  = 5
);
  localparam int REC_W = 3 + BP_W + CNT_W;

  logic             rec_valid;
  logic             rec_ready;
  logic [REC_W-1:0] rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/mq_pass_length_recorder_rec_fifo.sv
// Small synchronous record FIFO with a registered head; a pushed entry becomes
// visible at the head one cycle after the push.
module mq_pass_length_recorder_rec_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             space,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic             head_valid_reg;
  logic [WIDTH-1:0] head_data_reg;
  logic             pop, push_ok;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop         = head_valid_reg & pop_ready;
  assign space       = (count_reg != FULL_CNT) | pop;
  assign push_ok     = push & space;
  assign rd_ptr_next = rd_ptr_reg + AW'(pop);
  assign count_next  = count_reg + (AW+1)'(push_ok) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_reg + AW'(push_ok);
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      head_valid_reg <= (count_next != '0);
      // Bypass when the entry being written is the next head.
      head_data_reg  <= (push_ok && (rd_ptr_next == wr_ptr_reg)) ? push_data : mem[rd_ptr_next];
    end
  end

  assign head_valid = head_valid_reg;
  assign head_data  = head_data_reg;

endmodule

// File: rtl/mq_pass_length_recorder.sv
// Counts MQ output bytes per code-block and queues one record per pass end,
// plus a final record after the code-block flush.
module mq_pass_length_recorder
  import mq_pass_length_recorder_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int BP_W       = BP_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rst_syn,
  input  logic                      cb_start,
  input  logic [BP_W-1:0]           msb_bp,
  input  logic                      byte_valid,
  input  logic                      word_last_sp,
  input  logic                      word_last_mrp,
  input  logic                      word_last_cp,
  input  logic                      bp_code_over,
  mq_pass_length_recorder_if.master rec,
  output logic                      cb_done,
  output logic                      rec_err
);
  localparam int REC_W    = 3 + BP_W + CNT_W;
  localparam int LAST_BIT = rec_last_bit(CNT_W, BP_W);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next, cnt_inc, len_now;
  logic [BP_W-1:0]  bp_reg, bp_next;
  logic [2:0]       wl_now, wl_reg, rise;
  logic             cb_done_reg, cb_done_next, rec_err_reg, err_set;
  logic             pass_end, multi_edge, cnt_max, final_pop, fifo_space, push;
  logic [1:0]       pass_sel;
  logic [REC_W-1:0] push_data;

  assign wl_now = {word_last_cp, word_last_mrp, word_last_sp};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      assign rise[gi] = wl_now[gi] & ~wl_reg[gi];
    end
  endgenerate

  assign pass_end   = |rise;
  assign multi_edge = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
  assign pass_sel   = rise[0] ? PASS_SP : (rise[1] ? PASS_MRP : PASS_CP);
  assign cnt_max    = &byte_cnt_reg;
  assign cnt_inc    = cnt_max ? byte_cnt_reg : byte_cnt_reg + CNT_W'(1);
  // Pass length includes a byte emitted in the terminating cycle.
  assign len_now    = byte_valid ? cnt_inc : byte_cnt_reg;
  assign final_pop  = rec.rec_valid & rec.rec_ready & rec.rec_data[LAST_BIT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         state_reg <= IDLE;
    else if (rst_syn) state_reg <= IDLE;
    else              state_reg <= state_next;
  end

  always_comb begin : next_state
    state_next = state_reg;
    if (cb_start) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN:     if (bp_code_over) state_next = (pass_end || !fifo_space) ? FLUSH : DONE;
        FLUSH:   if (fifo_space) state_next = DONE;
        DONE:    if (final_pop) state_next = IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin : outputs
    push          = 1'b0;
    push_data     = '0;
    byte_cnt_next = byte_cnt_reg;
    bp_next       = bp_reg;
    cb_done_next  = cb_done_reg;
    err_set       = 1'b0;
    if (cb_start) begin
      byte_cnt_next = '0;
      bp_next       = msb_bp;
      cb_done_next  = 1'b0;
      err_set       = (state_reg != IDLE);
    end else begin
      case (state_reg)
        IDLE: err_set = byte_valid | pass_end | bp_code_over;
        RUN: begin
          if (byte_valid) begin
            byte_cnt_next = cnt_inc;
            if (cnt_max) err_set = 1'b1;
          end
          if (pass_end) begin
            push      = 1'b1;
            push_data = {1'b0, pass_sel, bp_reg, len_now};
            if (multi_edge || !fifo_space) err_set = 1'b1;
            if (pass_sel == PASS_CP && bp_reg != '0) bp_next = bp_reg - BP_W'(1);
          end else if (bp_code_over && fifo_space) begin
            push      = 1'b1;
            push_data = {1'b1, PASS_FINAL, bp_reg, len_now};
          end
        end
        FLUSH: begin
          // The final record waits here for space rather than being dropped.
          if (fifo_space) begin
            push      = 1'b1;
            push_data = {1'b1, PASS_FINAL, bp_reg, byte_cnt_reg};
          end
        end
        DONE: if (final_pop) cb_done_next = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_reg <= '0;
      bp_reg       <= '0;
      wl_reg       <= '0;
      cb_done_reg  <= 1'b0;
      rec_err_reg  <= 1'b0;
    end else if (rst_syn) begin
      byte_cnt_reg <= '0;
      bp_reg       <= '0;
      wl_reg       <= '0;
      cb_done_reg  <= 1'b0;
      rec_err_reg  <= 1'b0;
    end else begin
      byte_cnt_reg <= byte_cnt_next;
      bp_reg       <= bp_next;
      wl_reg       <= wl_now;
      cb_done_reg  <= cb_done_next;
      rec_err_reg  <= rec_err_reg | err_set;
    end
  end

  mq_pass_length_recorder_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (rst_syn),
    .push       (push),
    .push_data  (push_data),
    .pop_ready  (rec.rec_ready),
    .space      (fifo_space),
    .head_valid (rec.rec_valid),
    .head_data  (rec.rec_data)
  );

  assign cb_done = cb_done_reg;
  assign rec_err = rec_err_reg;

endmodule

// File: tb/tb_mq_pass_length_recorder.sv
// Bench for the pass-length recorder: table vectors, directed corner cases and
// random traffic against a queue-based reference model.
module tb_mq_pass_length_recorder;
  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_RUN = 1, P_FLUSH = 2, P_DONE = 3;

  logic       clk = 1'b0;
  logic       rst, rst_syn, cb_start, byte_valid;
  logic [4:0] msb_bp;
  logic       word_last_sp, word_last_mrp, word_last_cp, bp_code_over;
  logic       cb_done, rec_err;

  mq_pass_length_recorder_if #(.CNT_W(16), .BP_W(5)) rec_if ();

  mq_pass_length_recorder dut (
    .clk           (clk),
    .rst           (rst),
    .rst_syn       (rst_syn),
    .cb_start      (cb_start),
    .msb_bp        (msb_bp),
    .byte_valid    (byte_valid),
    .word_last_sp  (word_last_sp),
    .word_last_mrp (word_last_mrp),
    .word_last_cp  (word_last_cp),
    .bp_code_over  (bp_code_over),
    .rec           (rec_if),
    .cb_done       (cb_done),
    .rec_err       (rec_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: phase of the block, byte count, bit-plane, queue.
  int          m_phase, m_cnt, m_bp;
  logic [2:0]  m_prev;
  bit          m_err, m_done;
  logic [23:0] q[$];

  typedef struct {
    bit          cs;
    int          msb;
    bit          bv, sp, mrp, cp, bco;
    bit          ev;
    logic [23:0] ed;
    bit          edone;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [23:0] mkrec(logic l, logic [1:0] p, logic [4:0] b, logic [15:0] n);
    return {l, p, b, n};
  endfunction

  function automatic vec_t mkv(bit cs, int msb, bit bv, bit sp, bit mrp, bit cp, bit bco,
                               bit ev, logic [23:0] ed, bit edone);
    vec_t v;
    v.cs = cs; v.msb = msb; v.bv = bv; v.sp = sp; v.mrp = mrp; v.cp = cp; v.bco = bco;
    v.ev = ev; v.ed = ed; v.edone = edone;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(bit cs, int msb, bit bv, bit sp, bit mrp, bit cp, bit bco, bit rdy);
    cb_start = cs; msb_bp = 5'(msb); byte_valid = bv;
    word_last_sp = sp; word_last_mrp = mrp; word_last_cp = cp;
    bp_code_over = bco; rec_if.rec_ready = rdy;
  endtask

  task automatic model_reset();
    q.delete();
    m_phase = P_IDLE; m_cnt = 0; m_bp = 0; m_prev = '0; m_err = 0; m_done = 0;
  endtask

  task automatic model_step();
    logic [2:0]  wl, rs;
    logic [1:0]  p;
    logic [23:0] r;
    bit          valid, pop, fpop, space, do_push;
    wl = {word_last_cp, word_last_mrp, word_last_sp};
    if (rst_syn) begin
      model_reset();
      return;
    end
    valid   = q.size() > 0;
    pop     = valid && rec_if.rec_ready;
    fpop    = pop && q[0][23];
    space   = (q.size() < DEPTH) || pop;
    rs      = wl & ~m_prev;
    do_push = 0;
    r       = '0;
    if (cb_start) begin
      if (m_phase != P_IDLE) m_err = 1;
      m_phase = P_RUN; m_cnt = 0; m_bp = int'(msb_bp); m_done = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (byte_valid || rs != 0 || bp_code_over) m_err = 1;
        P_RUN: begin
          if (byte_valid) begin
            if (m_cnt == 65535) m_err = 1;
            else m_cnt++;
          end
          if (rs != 0) begin
            p = rs[0] ? 2'd1 : (rs[1] ? 2'd2 : 2'd3);
            if ($countones(rs) > 1) m_err = 1;
            r = mkrec(1'b0, p, 5'(m_bp), 16'(m_cnt));
            if (space) do_push = 1; else m_err = 1;
            if (p == 2'd3 && m_bp > 0) m_bp--;
            if (bp_code_over) m_phase = P_FLUSH;
          end else if (bp_code_over) begin
            if (space) begin
              do_push = 1; r = mkrec(1'b1, 2'd0, 5'(m_bp), 16'(m_cnt)); m_phase = P_DONE;
            end else m_phase = P_FLUSH;
          end
        end
        P_FLUSH: if (space) begin
          do_push = 1; r = mkrec(1'b1, 2'd0, 5'(m_bp), 16'(m_cnt)); m_phase = P_DONE;
        end
        default: if (fpop) begin m_done = 1; m_phase = P_IDLE; end
      endcase
    end
    if (pop) begin
      $display("rec last=%0d pass=%0d bp=%0d len=%0d", q[0][23], q[0][22:21], q[0][20:16], q[0][15:0]);
      void'(q.pop_front());
    end
    if (do_push) q.push_back(r);
    m_prev = wl;
  endtask

  // One clock: advance the model with the current inputs, then compare after the edge.
  task automatic cyc();
    bit mv;
    model_step();
    @(posedge clk);
    #1;
    mv = q.size() > 0;
    chk("rec_valid", 32'(rec_if.rec_valid), 32'(mv));
    if (mv) chk("rec_data", 32'(rec_if.rec_data), 32'(q[0]));
    chk("cb_done", 32'(cb_done), 32'(m_done));
    chk("rec_err", 32'(rec_err), 32'(m_err));
  endtask

  bit r_sp, r_mrp, r_cp;

  initial begin
    tbl[0]  = mkv(1, 7, 0, 0, 0, 0, 0, 0, 24'h0, 0);
    for (int i = 1; i <= 5; i++) tbl[i] = mkv(0, 0, 1, 0, 0, 0, 0, 0, 24'h0, 0);
    tbl[6]  = mkv(0, 0, 0, 0, 0, 1, 0, 1, mkrec(1'b0, 2'b11, 5'd7, 16'd5), 0);
    tbl[7]  = mkv(0, 0, 1, 0, 0, 1, 0, 0, 24'h0, 0);
    tbl[8]  = mkv(0, 0, 1, 0, 0, 1, 0, 0, 24'h0, 0);
    tbl[9]  = mkv(0, 0, 1, 0, 0, 1, 0, 0, 24'h0, 0);
    tbl[10] = mkv(0, 0, 0, 1, 0, 1, 0, 1, mkrec(1'b0, 2'b01, 5'd6, 16'd8), 0);
    tbl[11] = mkv(0, 0, 0, 1, 0, 1, 1, 1, mkrec(1'b1, 2'b00, 5'd6, 16'd8), 0);
    tbl[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 24'h0, 1);
    tbl[13] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 24'h0, 1);

    rst = 1'b0; rst_syn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(rec_if.rec_valid), 32'd0);
    chk("reset_done", 32'(cb_done), 32'd0);
    chk("reset_err", 32'(rec_err), 32'd0);
    rst = 1'b1;

    // Basic block: CP then SP pass, then flush
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].cs, tbl[i].msb, tbl[i].bv, tbl[i].sp, tbl[i].mrp, tbl[i].cp, tbl[i].bco, 1);
      cyc();
      chk($sformatf("tbl%0d_valid", i), 32'(rec_if.rec_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 32'(rec_if.rec_data), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_done", i), 32'(cb_done), 32'(tbl[i].edone));
      chk($sformatf("tbl%0d_err", i), 32'(rec_err), 32'd0);
    end

    // Byte in the same cycle as the MRP edge is counted
    drive(1, 4, 0, 0, 0, 0, 0, 1); cyc();
    drive(0, 0, 1, 0, 0, 0, 0, 1); repeat (9) cyc();
    drive(0, 0, 1, 0, 1, 0, 0, 1); cyc();
    chk("mrp_len10", 32'(rec_if.rec_data), 32'(mkrec(1'b0, 2'b10, 5'd4, 16'd10)));
    drive(0, 0, 0, 0, 1, 0, 1, 1); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 1); cyc();
    chk("mrp_done", 32'(cb_done), 32'd1);

    // CP edge coinciding with the flush
    drive(1, 3, 0, 0, 0, 0, 0, 1); cyc();
    drive(0, 0, 1, 0, 0, 0, 0, 1); repeat (2) cyc();
    drive(0, 0, 0, 0, 0, 1, 1, 1); cyc();
    chk("coin_cp", 32'(rec_if.rec_data), 32'(mkrec(1'b0, 2'b11, 5'd3, 16'd2)));
    drive(0, 0, 0, 0, 0, 1, 0, 1); cyc();
    chk("coin_final", 32'(rec_if.rec_data), 32'(mkrec(1'b1, 2'b00, 5'd2, 16'd2)));
    drive(0, 0, 0, 0, 0, 0, 0, 1); cyc();
    chk("coin_done", 32'(cb_done), 32'd1);

    // Overflow with downstream stalled; final record waits in FLUSH
    drive(1, 5, 0, 0, 0, 0, 0, 0); cyc();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 1, 0, 0, 0, 0); cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0); cyc();
    end
    chk("ovf_err", 32'(rec_err), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0); repeat (3) cyc();
    chk("ovf_head", 32'(rec_if.rec_data), 32'(mkrec(1'b0, 2'b01, 5'd5, 16'd1)));
    drive(0, 0, 0, 0, 0, 0, 0, 1); repeat (7) cyc();
    chk("ovf_done", 32'(cb_done), 32'd1);

    // Synchronous clear with two queued records
    drive(1, 3, 0, 0, 0, 0, 0, 0); cyc();
    drive(0, 0, 1, 1, 0, 0, 0, 0); cyc();
    drive(0, 0, 1, 0, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0); rst_syn = 1'b1; cyc(); rst_syn = 1'b0;
    chk("clr_valid", 32'(rec_if.rec_valid), 32'd0);
    chk("clr_err", 32'(rec_err), 32'd0);
    drive(1, 2, 0, 0, 0, 0, 0, 1); cyc();
    drive(0, 0, 0, 1, 0, 0, 0, 1); cyc();
    chk("clr_len0", 32'(rec_if.rec_data), 32'(mkrec(1'b0, 2'b01, 5'd2, 16'd0)));
    drive(0, 0, 0, 1, 0, 0, 1, 1); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 1); cyc();

    // Counter saturation and bit-plane floor at zero
    drive(1, 0, 0, 0, 0, 0, 0, 1); cyc();
    drive(0, 0, 1, 0, 0, 0, 0, 1); repeat (65535) cyc();
    chk("sat_err_before", 32'(rec_err), 32'd0);
    cyc();
    chk("sat_err_after", 32'(rec_err), 32'd1);
    drive(0, 0, 0, 0, 0, 1, 0, 1); cyc();
    chk("sat_cp1", 32'(rec_if.rec_data), 32'(mkrec(1'b0, 2'b11, 5'd0, 16'hFFFF)));
    drive(0, 0, 0, 0, 0, 0, 0, 1); cyc();
    drive(0, 0, 0, 0, 0, 1, 0, 1); cyc();
    chk("sat_cp2", 32'(rec_if.rec_data), 32'(mkrec(1'b0, 2'b11, 5'd0, 16'hFFFF)));
    drive(0, 0, 0, 0, 0, 1, 1, 1); cyc();
    chk("sat_final", 32'(rec_if.rec_data), 32'(mkrec(1'b1, 2'b00, 5'd0, 16'hFFFF)));
    drive(0, 0, 0, 0, 0, 0, 0, 1); cyc();
    chk("sat_done", 32'(cb_done), 32'd1);

    // Random traffic against the reference model
    r_sp = 0; r_mrp = 0; r_cp = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(11) == 0) r_sp  = ~r_sp;
      if ($urandom_range(11) == 0) r_mrp = ~r_mrp;
      if ($urandom_range(11) == 0) r_cp  = ~r_cp;
      drive($urandom_range(39) == 0, int'($urandom_range(31)), $urandom_range(1) == 1,
            r_sp, r_mrp, r_cp, $urandom_range(49) == 0, $urandom_range(9) < 7);
      rst_syn = ($urandom_range(799) == 0);
      cyc();
    end
    rst_syn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (8) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
